div: RTL and testbench
======================

Name: div

Overview:
- Multi-cycle radix-2 restoring divider and its sequencing FSM.
- Serves the EX stage, which drives start/annul and stalls the pipeline until `ready_o` rises.
- Handles signed and unsigned DIV/DIVU.
- Result is packed {remainder, quotient} so EX can write HI/LO directly.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W; step count equals DATA_W.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low (asserted when 0 at a rising clk edge)
signed_div_i  input  1  1 = signed division (DIV), 0 = unsigned (DIVU); sampled at start
opdata1_i  input  DATA_W  dividend; sampled at start
opdata2_i  input  DATA_W  divisor; sampled at start
start_i  input  1  request/hold; must stay 1 until ready_o seen, then drop
annul_i  input  1  abort request (exception/flush); kills an in-flight division
result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}; valid only while ready_o=1, else 0
ready_o  output  1  result valid

Behaviour:
- Reset (rst=0 at edge): state=DivFree, counter=0, internal registers cleared; ready_o=0, result_o=0. Reset overrides everything, including mid-division.
- One clock and one reset only; all outputs are registered.

State DivFree:
- If start_i=1 and annul_i=0, latch operands and the sign mode.
- Signed mode: operands are replaced by their two's-complement absolute values.
- If divisor==0, go to DivByZero; else go to DivOn with counter=0.
- start_i with annul_i=1 is ignored; stay in DivFree.

State DivByZero:
- Go to DivEnd with result register = 0.
- ready_o rises 2 edges after the start-sampling edge.

State DivOn:
- annul_i=1 at any edge: go to DivFree, ready_o stays 0, result discarded.
- Otherwise perform one restoring step per edge:
  - trial = partial remainder minus divisor, computed DATA_W+1 bits wide.
  - If it is negative, shift in quotient bit 0; else replace the remainder with the trial and shift in 1.
  - counter++.
- On the edge where counter==DATA_W, no step is taken:
  - Signed fix-up: negate quotient if operand signs differed; negate remainder if the dividend was negative.
  - Load result, set ready_o=1, go to DivEnd.
- ready_o rises exactly DATA_W+1 = 33 edges after the start-sampling edge.

State DivEnd:
- ready_o=1, result_o stable while start_i=1. annul_i is ignored here.
- On the first edge with start_i=0: ready_o=0, result_o=0, go to DivFree.
- A new start is accepted on the following edge (no back-to-back start from DivEnd).

Arithmetic:
- Quotient and remainder are truncated to DATA_W.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0 (wraps, no trap).
- Signed results satisfy dividend = q*d + r, with r carrying the dividend's sign.

Operand stability:
- Inputs other than start_i/annul_i are don't-care after the start-sampling edge.

Test Plan:
- Unsigned 100/7: start_i=1 at edge 0 → ready_o=1 at edge 33; result_o=0x00000002_0000000E; held while start_i=1; start_i→0 gives ready_o=0, result_o=0 the next edge.
- Signed -7/2 (0xFFFFFFF9/0x00000002) → result_o=0xFFFFFFFF_FFFFFFFD at edge 33. Signed 7/-2 → 0x00000001_FFFFFFFD.
- Divide by zero: opdata2_i=0, both modes → ready_o=1 at edge 2, result_o=0. Also signed 0x80000000/0xFFFFFFFF → 0x00000000_80000000.
- Annul: annul_i=1 at edge 10 of a division → state DivFree at edge 10, ready_o never rises. New start 0xFFFFFFFF/0x10 (unsigned) at edge 11 → 0x0000000F_0FFFFFFF at edge 44.
- Reset mid-op: rst=0 at edge 20 → ready_o=0, result_o=0 at edge 20. Start with annul_i=1 in DivFree → ignored, ready_o stays 0 for 40 cycles.
- Back-to-back: drop start_i one cycle after ready_o, reassert next cycle with new operands → second result correct, ready_o low for at least 1 cycle between results.

Source files
------------

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) producing {remainder, quotient}.
// Latency: DATA_W+1 edges from the start-sampling edge, or 2 edges for a zero divisor.
// Backpressure: the result is held while start_i stays high; dropping start_i releases it.
module div #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        DivFree,
        DivByZero,
        DivOn,
        DivEnd
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [DATA_W-1:0]   rem, rem_nxt;
    logic [DATA_W-1:0]   quo, quo_nxt;
    logic [DATA_W-1:0]   dsr, dsr_nxt;
    logic                neg_q, neg_q_nxt;
    logic                neg_r, neg_r_nxt;
    logic [2*DATA_W-1:0] res, res_nxt;
    logic [2*DATA_W-1:0] result_nxt;
    logic                ready_nxt;

    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     trial;
    logic [DATA_W-1:0]   q_fix;
    logic [DATA_W-1:0]   r_fix;
    logic                a_neg;
    logic                b_neg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= DivFree;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dsr      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            res      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rem      <= rem_nxt;
            quo      <= quo_nxt;
            dsr      <= dsr_nxt;
            neg_q    <= neg_q_nxt;
            neg_r    <= neg_r_nxt;
            res      <= res_nxt;
            result_o <= result_nxt;
            ready_o  <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rem_nxt    = rem;
        quo_nxt    = quo;
        dsr_nxt    = dsr;
        neg_q_nxt  = neg_q;
        neg_r_nxt  = neg_r;
        res_nxt    = res;
        result_nxt = '0;
        ready_nxt  = 1'b0;
        a_neg      = signed_div_i & opdata1_i[DATA_W-1];
        b_neg      = signed_div_i & opdata2_i[DATA_W-1];

        // Remainder below divisor keeps shifted < 2*divisor, so DATA_W+1 bits never overflow.
        shifted = {rem, quo[DATA_W-1]};
        trial   = shifted - {1'b0, dsr};
        q_fix   = neg_q ? -quo : quo;
        r_fix   = neg_r ? -rem : rem;

        case (state)
            DivFree: begin
                if (start_i && !annul_i) begin
                    quo_nxt   = a_neg ? -opdata1_i : opdata1_i;
                    dsr_nxt   = b_neg ? -opdata2_i : opdata2_i;
                    rem_nxt   = '0;
                    cnt_nxt   = '0;
                    neg_q_nxt = a_neg ^ b_neg;
                    neg_r_nxt = a_neg;
                    state_nxt = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                res_nxt   = '0;
                state_nxt = DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    state_nxt = DivFree;
                end else if (cnt == CNT_W'(DATA_W)) begin
                    res_nxt    = {r_fix, q_fix};
                    result_nxt = {r_fix, q_fix};
                    ready_nxt  = 1'b1;
                    state_nxt  = DivEnd;
                end else begin
                    if (trial[DATA_W]) begin
                        rem_nxt = shifted[DATA_W-1:0];
                        quo_nxt = {quo[DATA_W-2:0], 1'b0};
                    end else begin
                        rem_nxt = trial[DATA_W-1:0];
                        quo_nxt = {quo[DATA_W-2:0], 1'b1};
                    end
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DivEnd: begin
                if (start_i) begin
                    ready_nxt  = 1'b1;
                    result_nxt = res;
                end else begin
                    state_nxt = DivFree;
                end
            end
            default: state_nxt = DivFree;
        endcase
    end

endmodule

// File: tb/tb_div.sv
// Directed bench for div: scoreboard of expected results, latency and handshake checks.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    logic [63:0] exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    div #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Entered just after the start-sampling edge; counts edges until ready, then holds and releases.
    task automatic wait_result(input string tag, input int exp_lat);
        int          lat;
        logic [63:0] exp;
        logic [63:0] got;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        got = result;
        exp = exp_q.pop_front();
        check({tag, " result"}, got, exp);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " hold ready"}, 64'(ready), 64'd1);
        check({tag, " hold result"}, result, exp);
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " drop ready"}, 64'(ready), 64'd0);
        check({tag, " drop result"}, result, 64'd0);
    endtask

    task automatic drive(input logic sg, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div = sg;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        annul      = 1'b0;
        exp_q.push_back(model(sg, a, b));
        @(posedge clk);
    endtask

    task automatic run_div(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b);
        drive(sg, a, b);
        @(negedge clk);
        op1 = $urandom;
        op2 = $urandom;
        signed_div = ~sg;
        wait_result(tag, (b == 32'd0) ? 2 : 33);
    endtask

    initial begin
        bit rose;
        rst        = 1'b0;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        op1        = '0;
        op2        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 64'(ready), 64'd0);
        check("reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div("u100/7", 1'b0, 32'd100, 32'd7);
        check("u100/7 constant", model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        run_div("s-7/2", 1'b1, 32'hFFFFFFF9, 32'h00000002);
        run_div("s7/-2", 1'b1, 32'h00000007, 32'hFFFFFFFE);
        run_div("u/0", 1'b0, 32'd1234, 32'd0);
        run_div("s/0", 1'b1, 32'h80000000, 32'd0);
        run_div("smin/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF);
        run_div("s-100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9);
        run_div("umax/1", 1'b0, 32'hFFFFFFFF, 32'd1);

        // Annul at edge 10, new start sampled at edge 11.
        @(negedge clk);
        signed_div = 1'b0;
        op1        = 32'd1000;
        op2        = 32'd3;
        start      = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        check("annul ready", 64'(ready), 64'd0);
        check("annul state", 64'(dut.state), 64'd0);
        drive(1'b0, 32'hFFFFFFFF, 32'h10);
        wait_result("annul restart", 33);

        // Reset mid-division at edge 20, then ready must stay low.
        @(negedge clk);
        signed_div = 1'b0;
        op1        = 32'd100;
        op2        = 32'd7;
        start      = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midreset ready", 64'(ready), 64'd0);
        check("midreset result", result, 64'd0);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        rose  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0) rose = 1'b1;
        end
        check("midreset quiet", 64'(rose), 64'd0);

        // Start with annul is ignored in DivFree.
        @(negedge clk);
        start = 1'b1;
        annul = 1'b1;
        op2   = 32'd0;
        rose  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0) rose = 1'b1;
        end
        check("annul start ignored", 64'(rose), 64'd0);
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        @(posedge clk);

        // Back-to-back: release one edge after ready, restart on the following edge.
        run_div("b2b first", 1'b0, 32'd77777, 32'd123);
        run_div("b2b second", 1'b1, 32'h80000001, 32'd16);

        check("scoreboard empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
